inst_fetch_unit: RTL and testbench

- Instruction fetch front end that produces the instruction words consumed by the main decoder, which extracts op/funct from them.
- Maintains the PC and issues single-outstanding requests to instruction memory over a req/addr_ok/data_ok handshake.
- Buffers returned words in a small prefetch FIFO and presents them to decode with a valid/ready handshake.
- Accepts branch/jump redirects from downstream and flushes stale instructions.

---
 rtl/inst_fetch_unit.sv | 197 +++++++++++++++++++
 tb/tb_inst_fetch_unit.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_unit.sv
// Instruction fetch front end: PC, single-outstanding memory handshake, prefetch FIFO, redirect flush.
// Optional macro FETCH_ALIGN_CHECK_EN adds id_adel and halts fetch on a misaligned PC.
module inst_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] id_inst,
    output logic [31:0] id_pc,
    output logic        id_valid,
`ifdef FETCH_ALIGN_CHECK_EN
    output logic        id_adel,
`endif
    input  logic        id_ready
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_t;

    state_t            state_q, state_d;
    logic [31:0]       fetch_pc_q, fetch_pc_d;
    logic [31:0]       req_pc_q, req_pc_d;
    logic [31:0]       inst_mem_q [FIFO_DEPTH];
    logic [31:0]       inst_mem_d [FIFO_DEPTH];
    logic [31:0]       pc_mem_q   [FIFO_DEPTH];
    logic [31:0]       pc_mem_d   [FIFO_DEPTH];
`ifdef FETCH_ALIGN_CHECK_EN
    logic              adel_mem_q [FIFO_DEPTH];
    logic              adel_mem_d [FIFO_DEPTH];
    logic              push_adel;
`endif
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [CNT_W-1:0]  count_after_push;

    logic              push;
    logic              pop;
    logic              flush;
    logic              misaligned;
    logic [31:0]       push_inst;
    logic [31:0]       push_pc;

`ifdef FETCH_ALIGN_CHECK_EN
    assign misaligned = (fetch_pc_q[1:0] != 2'b00);
    assign inst_addr  = fetch_pc_q;
    assign id_adel    = adel_mem_q[rd_ptr_q];
`else
    assign misaligned = 1'b0;
    assign inst_addr  = {fetch_pc_q[31:2], 2'b00};
`endif

    assign id_valid = (count_q != '0);
    assign id_inst  = inst_mem_q[rd_ptr_q];
    assign id_pc    = pc_mem_q[rd_ptr_q];
    assign pop      = id_valid & id_ready & ~redirect;

    // Occupancy after a response push in WAIT, used to decide whether another slot is free.
    assign count_after_push = count_q + CNT_W'(1) - CNT_W'(id_valid & id_ready);

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        inst_req   = 1'b0;
        push       = 1'b0;
        flush      = 1'b0;
        push_inst  = inst_rdata;
        push_pc    = req_pc_q;
`ifdef FETCH_ALIGN_CHECK_EN
        push_adel  = 1'b0;
`endif

        case (state_q)
            IDLE: begin
                if (count_q < DEPTH_C && !misaligned) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (misaligned) begin
                    // Misaligned PC reports an exception entry instead of fetching, then halts.
                    push      = 1'b1;
                    push_inst = 32'h0;
                    push_pc   = fetch_pc_q;
`ifdef FETCH_ALIGN_CHECK_EN
                    push_adel = 1'b1;
`endif
                    state_d   = IDLE;
                end else begin
                    inst_req = 1'b1;
                    if (inst_addr_ok) begin
                        req_pc_d   = fetch_pc_q;
                        fetch_pc_d = fetch_pc_q + 32'd4;
                        state_d    = WAIT;
                    end
                end
            end
            WAIT: begin
                if (inst_data_ok) begin
                    push    = 1'b1;
                    state_d = (count_after_push < DEPTH_C) ? REQ : IDLE;
                end
            end
            DROP: begin
                if (inst_data_ok) begin
                    state_d = REQ;
                end
            end
            default: state_d = IDLE;
        endcase

        // A response landing in the redirect cycle is the stale one, so no DROP is needed then.
        if (redirect) begin
            push       = 1'b0;
            flush      = 1'b1;
            fetch_pc_d = redirect_pc;
            case (state_q)
                REQ:       state_d = (inst_req && inst_addr_ok) ? DROP : REQ;
                WAIT, DROP: state_d = inst_data_ok ? REQ : DROP;
                default:   state_d = REQ;
            endcase
        end
    end

    always_comb begin
        inst_mem_d = inst_mem_q;
        pc_mem_d   = pc_mem_q;
`ifdef FETCH_ALIGN_CHECK_EN
        adel_mem_d = adel_mem_q;
`endif
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;

        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                inst_mem_d[wr_ptr_q] = push_inst;
                pc_mem_d[wr_ptr_q]   = push_pc;
`ifdef FETCH_ALIGN_CHECK_EN
                adel_mem_d[wr_ptr_q] = push_adel;
`endif
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                inst_mem_q[i] <= '0;
                pc_mem_q[i]   <= '0;
`ifdef FETCH_ALIGN_CHECK_EN
                adel_mem_q[i] <= 1'b0;
`endif
            end
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            inst_mem_q <= inst_mem_d;
            pc_mem_q   <= pc_mem_d;
`ifdef FETCH_ALIGN_CHECK_EN
            adel_mem_q <= adel_mem_d;
`endif
        end
    end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Self-checking bench for inst_fetch_unit: randomized memory/decode traffic against a transaction-level model.
module tb_inst_fetch_unit;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] id_inst;
    logic [31:0] id_pc;
    logic        id_valid;
    logic        id_ready;
`ifdef FETCH_ALIGN_CHECK_EN
    logic        id_adel;
`endif

    inst_fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .id_inst      (id_inst),
        .id_pc        (id_pc),
        .id_valid     (id_valid),
`ifdef FETCH_ALIGN_CHECK_EN
        .id_adel      (id_adel),
`endif
        .id_ready     (id_ready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;
    int lat_min = 1;
    int lat_max = 1;
    int aok_pct = 100;

    typedef struct { logic [31:0] pc; logic [31:0] inst; } entry_t;
    typedef struct { logic [31:0] addr; int gen; } req_t;

    entry_t      exp_q[$];
    req_t        infl_q[$];
    int          gen = 0;
    logic [31:0] exp_addr = 32'h0;
    logic [31:0] acc_log[$];
    logic [31:0] pop_log[$];

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    // Instruction memory: accepts when inst_req, answers after lat_min..lat_max cycles.
    initial begin
        logic [31:0] p_addr;
        logic [31:0] acc_addr;
        int          p_cnt;
        bit          p_valid;
        bit          acc_pend;
        p_valid = 0; acc_pend = 0; p_cnt = 0; p_addr = '0; acc_addr = '0;
        inst_addr_ok = 1'b0; inst_data_ok = 1'b0; inst_rdata = '0;
        forever begin
            @(posedge clk); #1;
            if (rst) begin
                p_valid = 0; acc_pend = 0;
                inst_addr_ok = 1'b0; inst_data_ok = 1'b0;
                continue;
            end
            if (inst_data_ok) p_valid = 0;
            if (acc_pend) begin
                p_valid  = 1;
                p_addr   = acc_addr;
                p_cnt    = $urandom_range(lat_max, lat_min) - 1;
                acc_pend = 0;
            end
            inst_data_ok = 1'b0;
            if (p_valid) begin
                if (p_cnt == 0) begin
                    inst_data_ok = 1'b1;
                    inst_rdata   = word_of(p_addr);
                end else begin
                    p_cnt--;
                end
            end
            if (!inst_data_ok) inst_rdata = $urandom;
            inst_addr_ok = 1'b0;
            if (inst_req && !p_valid) begin
                inst_addr_ok = ($urandom_range(99, 0) < aok_pct);
                if (inst_addr_ok) begin
                    acc_pend = 1;
                    acc_addr = inst_addr;
                end
            end
        end
    end

    // Reference model: accepted requests carry a redirect generation; stale ones are never delivered.
    initial begin
        req_t   r;
        entry_t e;
        forever begin
            @(negedge clk);
            if (rst || !mon_en) begin
                exp_q.delete(); infl_q.delete(); exp_addr = 32'h0;
                continue;
            end
            checks++;
            if (id_valid !== (exp_q.size() != 0)) begin
                errors++;
                $display("FAIL mon_id_valid: got %b expected %b at %0t", id_valid, exp_q.size() != 0, $time);
            end
            if (exp_q.size() != 0) begin
                checks++;
                if (id_pc !== exp_q[0].pc) begin
                    errors++;
                    $display("FAIL mon_id_pc: got %h expected %h at %0t", id_pc, exp_q[0].pc, $time);
                end
                checks++;
                if (id_inst !== exp_q[0].inst) begin
                    errors++;
                    $display("FAIL mon_id_inst: got %h expected %h at %0t", id_inst, exp_q[0].inst, $time);
                end
`ifdef FETCH_ALIGN_CHECK_EN
                checks++;
                if (id_adel !== 1'b0) begin
                    errors++;
                    $display("FAIL mon_id_adel: got %b expected 0 at %0t", id_adel, $time);
                end
`endif
            end
            if (inst_req) begin
                checks++;
                if (exp_q.size() >= DEPTH || infl_q.size() != 0) begin
                    errors++;
                    $display("FAIL mon_req_slot: got fifo=%0d inflight=%0d required fifo<%0d inflight=0 at %0t",
                             exp_q.size(), infl_q.size(), DEPTH, $time);
                end
            end
            if (inst_req && inst_addr_ok) begin
                checks++;
                if (inst_addr !== exp_addr) begin
                    errors++;
                    $display("FAIL mon_inst_addr: got %h expected %h at %0t", inst_addr, exp_addr, $time);
                end
                acc_log.push_back(inst_addr);
                r.addr = inst_addr; r.gen = gen;
                infl_q.push_back(r);
                exp_addr = exp_addr + 32'd4;
            end
            if (id_valid && id_ready && !redirect && exp_q.size() != 0) begin
                pop_log.push_back(id_pc);
                void'(exp_q.pop_front());
            end
            if (inst_data_ok && infl_q.size() != 0) begin
                r = infl_q.pop_front();
                if (r.gen == gen && !redirect) begin
                    e.pc = r.addr; e.inst = word_of(r.addr);
                    exp_q.push_back(e);
                end
            end
            if (redirect) begin
                exp_q.delete();
                gen++;
                exp_addr = redirect_pc;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step();
        @(posedge clk); #2;
    endtask

    task automatic do_reset();
        step(); rst = 1'b1;
        step(); step(); rst = 1'b0;
    endtask

    task automatic test_reset();
        lat_min = 1; lat_max = 1; aok_pct = 100;
        id_ready = 1'b0; redirect = 1'b0;
        step(); rst = 1'b0;
        repeat (4) step();
        rst = 1'b1; #1;
        checks++; if (inst_req !== 1'b0) begin errors++; $display("FAIL reset_inst_req: got %b expected 0", inst_req); end
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL reset_id_valid: got %b expected 0", id_valid); end
        checks++; if (id_inst !== 32'h0) begin errors++; $display("FAIL reset_id_inst: got %h expected 0", id_inst); end
        checks++; if (id_pc !== 32'h0) begin errors++; $display("FAIL reset_id_pc: got %h expected 0", id_pc); end
`ifdef FETCH_ALIGN_CHECK_EN
        checks++; if (id_adel !== 1'b0) begin errors++; $display("FAIL reset_id_adel: got %b expected 0", id_adel); end
`endif
        step();
        checks++; if (inst_req !== 1'b0) begin errors++; $display("FAIL reset_hold_inst_req: got %b expected 0", inst_req); end
        step(); rst = 1'b0;
    endtask

    task automatic test_sequential();
        id_ready = 1'b1; lat_min = 1; lat_max = 1; aok_pct = 100;
        do_reset();
        acc_log.delete(); pop_log.delete();
        for (int i = 0; i < 40 && pop_log.size() < 3; i++) step();
        checks++;
        if (pop_log.size() < 3 || acc_log.size() < 3) begin
            errors++;
            $display("FAIL seq_progress: got %0d pops expected at least 3", pop_log.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (acc_log[i] !== 32'(4 * i)) begin errors++; $display("FAIL seq_addr%0d: got %h expected %h", i, acc_log[i], 32'(4 * i)); end
                checks++;
                if (pop_log[i] !== 32'(4 * i)) begin errors++; $display("FAIL seq_pc%0d: got %h expected %h", i, pop_log[i], 32'(4 * i)); end
            end
        end
    endtask

    task automatic test_backpressure();
        id_ready = 1'b0; lat_min = 1; lat_max = 1; aok_pct = 100;
        do_reset();
        acc_log.delete(); pop_log.delete();
        repeat (10) step();
        checks++; if (inst_req !== 1'b0) begin errors++; $display("FAIL full_inst_req: got %b expected 0", inst_req); end
        checks++; if (id_valid !== 1'b1) begin errors++; $display("FAIL full_id_valid: got %b expected 1", id_valid); end
        checks++; if (acc_log.size() != 2) begin errors++; $display("FAIL full_accepts: got %0d expected 2", acc_log.size()); end
        id_ready = 1'b1;
        for (int i = 0; i < 20 && pop_log.size() < 2; i++) step();
        checks++;
        if (pop_log.size() < 2) begin
            errors++; $display("FAIL drain_progress: got %0d pops expected 2", pop_log.size());
        end else begin
            checks++; if (pop_log[0] !== 32'h0) begin errors++; $display("FAIL drain_pc0: got %h expected 0", pop_log[0]); end
            checks++; if (pop_log[1] !== 32'h4) begin errors++; $display("FAIL drain_pc1: got %h expected 4", pop_log[1]); end
        end
    endtask

    task automatic test_redirect_wait();
        bit hit;
        int k;
        id_ready = 1'b1; lat_min = 3; lat_max = 3; aok_pct = 100;
        do_reset();
        acc_log.delete(); pop_log.delete();
        hit = 0;
        for (int i = 0; i < 60 && !hit; i++) begin
            step();
            foreach (acc_log[j]) if (acc_log[j] == 32'h8) hit = 1;
        end
        checks++;
        if (!hit) begin errors++; $display("FAIL rdw_reach_8: got no accept of 8 expected one"); end
        redirect = 1'b1; redirect_pc = 32'h100; lat_min = 1; lat_max = 1;
        step(); redirect = 1'b0;
        acc_log.delete(); pop_log.delete();
        k = 1;
        while (!id_valid && k < 40) begin step(); k++; end
        checks++;
        if (k < 3) begin errors++; $display("FAIL rdw_latency: got %0d cycles expected at least 3", k); end
        for (int i = 0; i < 20 && pop_log.size() < 1; i++) step();
        checks++;
        if (pop_log.size() < 1 || acc_log.size() < 1) begin
            errors++; $display("FAIL rdw_progress: got %0d pops expected at least 1", pop_log.size());
        end else begin
            checks++; if (acc_log[0] !== 32'h100) begin errors++; $display("FAIL rdw_addr: got %h expected 100", acc_log[0]); end
            checks++; if (pop_log[0] !== 32'h100) begin errors++; $display("FAIL rdw_pc: got %h expected 100", pop_log[0]); end
        end
    endtask

    task automatic test_redirect_pop_push();
        bit hit;
        id_ready = 1'b0; lat_min = 2; lat_max = 2; aok_pct = 100;
        do_reset();
        hit = 0;
        for (int i = 0; i < 60 && !hit; i++) begin
            step();
            if (inst_data_ok && id_valid) begin
                id_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h300; hit = 1;
            end
        end
        checks++;
        if (!hit) begin errors++; $display("FAIL rpp_setup: got no push+pop cycle expected one"); end
        step(); redirect = 1'b0;
        acc_log.delete(); pop_log.delete();
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL rpp_flush: got id_valid %b expected 0", id_valid); end
        for (int i = 0; i < 30 && pop_log.size() < 1; i++) step();
        checks++;
        if (pop_log.size() < 1 || acc_log.size() < 1) begin
            errors++; $display("FAIL rpp_progress: got %0d pops expected at least 1", pop_log.size());
        end else begin
            checks++; if (acc_log[0] !== 32'h300) begin errors++; $display("FAIL rpp_addr: got %h expected 300", acc_log[0]); end
            checks++; if (pop_log[0] !== 32'h300) begin errors++; $display("FAIL rpp_pc: got %h expected 300", pop_log[0]); end
        end
    endtask

    task automatic test_wrap();
        id_ready = 1'b1; lat_min = 1; lat_max = 1; aok_pct = 100;
        step(); redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        step(); redirect = 1'b0;
        acc_log.delete(); pop_log.delete();
        for (int i = 0; i < 40 && (acc_log.size() < 2 || pop_log.size() < 2); i++) step();
        checks++;
        if (acc_log.size() < 2 || pop_log.size() < 2) begin
            errors++; $display("FAIL wrap_progress: got %0d accepts expected at least 2", acc_log.size());
        end else begin
            checks++; if (acc_log[0] !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_addr0: got %h expected fffffffc", acc_log[0]); end
            checks++; if (acc_log[1] !== 32'h0) begin errors++; $display("FAIL wrap_addr1: got %h expected 0", acc_log[1]); end
            checks++; if (pop_log[1] !== 32'h0) begin errors++; $display("FAIL wrap_pc1: got %h expected 0", pop_log[1]); end
        end
    endtask

    task automatic test_random();
        logic [31:0] t;
        lat_min = 1; lat_max = 4; aok_pct = 60;
        pop_log.delete();
        for (int i = 0; i < 1500; i++) begin
            step();
            id_ready = ($urandom_range(3, 0) != 0);
            redirect = ($urandom_range(99, 0) < 3);
            t = $urandom;
            redirect_pc = ($urandom_range(9, 0) == 0) ? 32'hFFFF_FFF8 : (t & 32'hFFFF_FFFC);
        end
        step(); redirect = 1'b0; id_ready = 1'b1;
        repeat (10) step();
        checks++;
        if (pop_log.size() < 50) begin errors++; $display("FAIL rand_progress: got %0d pops expected at least 50", pop_log.size()); end
    endtask

`ifdef FETCH_ALIGN_CHECK_EN
    task automatic test_align_check();
        bit seen_req;
        mon_en = 1'b0; id_ready = 1'b0; lat_min = 1; lat_max = 1; aok_pct = 100;
        do_reset();
        repeat (3) step();
        redirect = 1'b1; redirect_pc = 32'h102;
        step(); redirect = 1'b0;
        seen_req = 0;
        repeat (8) begin step(); if (inst_req) seen_req = 1; end
        checks++; if (seen_req !== 1'b0) begin errors++; $display("FAIL adel_no_req: got req %b expected 0", seen_req); end
        checks++; if (id_valid !== 1'b1) begin errors++; $display("FAIL adel_valid: got %b expected 1", id_valid); end
        checks++; if (id_adel !== 1'b1) begin errors++; $display("FAIL adel_flag: got %b expected 1", id_adel); end
        checks++; if (id_pc !== 32'h102) begin errors++; $display("FAIL adel_pc: got %h expected 102", id_pc); end
        checks++; if (id_inst !== 32'h0) begin errors++; $display("FAIL adel_inst: got %h expected 0", id_inst); end
        redirect = 1'b1; redirect_pc = 32'h200;
        step(); redirect = 1'b0;
        for (int i = 0; i < 20 && !id_valid; i++) step();
        checks++; if (id_valid !== 1'b1) begin errors++; $display("FAIL adel_resume_valid: got %b expected 1", id_valid); end
        checks++; if (id_pc !== 32'h200) begin errors++; $display("FAIL adel_resume_pc: got %h expected 200", id_pc); end
        checks++; if (id_adel !== 1'b0) begin errors++; $display("FAIL adel_resume_flag: got %b expected 0", id_adel); end
        checks++; if (id_inst !== word_of(32'h200)) begin errors++; $display("FAIL adel_resume_inst: got %h expected %h", id_inst, word_of(32'h200)); end
        do_reset();
        mon_en = 1'b1;
    endtask
`endif

    initial begin
        rst = 1'b1; id_ready = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        mon_en = 1'b1;
        $display("[TB] start");
        test_reset();
        test_sequential();
        test_backpressure();
        test_redirect_wait();
        test_redirect_pop_push();
        test_wrap();
        test_random();
`ifdef FETCH_ALIGN_CHECK_EN
        test_align_check();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
